rr_mux4_sched: RTL and testbench
================================

Name: rr_mux4_sched

Overview:
- Upstream control stage for the 4-channel, 4-bit 4:1 mux datapath.
- Arbitrates four valid/ready input channels (a, b, c, d) with a round-robin scheme.
- Drives the registered select pair S1:S0 that the downstream mux consumes.
- Holds the granted word in a one-entry output register with a valid/ready handshake toward the consumer.

Parameters:
- WIDTH, 4, data width of each channel and of op_data.
- CNT_W, 8, width of each per-channel grant counter; used only when GRANT_CNT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  channel 0 data.
- b  input  WIDTH  channel 1 data.
- c  input  WIDTH  channel 2 data.
- d  input  WIDTH  channel 3 data.
- in_valid  input  4  per-channel request; bit k = channel k (0=a, 1=b, 2=c, 3=d).
- in_ready  output  4  per-channel accept, combinational, at most one bit set.
- S0  output  1  registered select LSB of the last granted channel.
- S1  output  1  registered select MSB of the last granted channel.
- op_data  output  WIDTH  registered output word.
- op_valid  output  1  op_data holds an unconsumed word.
- op_ready  input  1  consumer accepts op_data this cycle.
- grant_cnt  output  4*CNT_W  per-channel grant counters; present only with GRANT_CNT_EN. Channel k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asynchronous assert, synchronous release):
  - op_valid=0, op_data=0, S1:S0=2'b00.
  - Round-robin pointer ptr=3, so channel 0 has highest priority first.
  - FSM enters EMPTY.
  - in_ready=0 while rst_n=0.
- FSM has two states:
  - EMPTY: op_valid=0.
  - FULL: op_valid=1.
- Load condition: load_ok = (state==EMPTY) | (op_ready & op_valid).
- Arbitration (combinational):
  - Search in_valid starting at ptr+1 mod 4, wrapping 3->0.
  - The first set bit k is the winner.
  - in_ready[k] = load_ok; all other in_ready bits are 0.
  - If no in_valid bit is set, in_ready=0.
- Transfer: occurs on channel k when in_valid[k] & in_ready[k] at a clock edge. On that edge:
  - op_data <= selected channel data.
  - op_valid <= 1.
  - {S1,S0} <= k.
  - ptr <= k.
  - Next state = FULL.
- Drain without refill: when op_ready & op_valid and no transfer occurs, op_valid <= 0 and next state = EMPTY. op_data, S1:S0 and ptr hold their values.
- Simultaneous drain and accept: the new word replaces the old in the same edge. This sustains 1 word/cycle throughput.
- Stall: in FULL with op_ready=0, the following are all stable:
  - op_data, S1:S0, op_valid=1.
  - in_ready=0 (back-pressure).
- Latency: a word accepted at edge N appears on op_data/op_valid after edge N (1 cycle).
- op_ready while EMPTY: ignored, no state change.
- Fairness:
  - Under continuous all-channel requests, the grant order is 0,1,2,3,0,…
  - A channel waits at most 3 grants.
- Single requester: it is granted every cycle that load_ok holds; ptr does not block repeat grants.
- in_valid dropping without a handshake is legal upstream; the block keeps no record of it.
- Reset mid-operation: a pending op_data word is discarded immediately. op_valid falls asynchronously with rst_n.

Optional Feature:
- Macro: GRANT_CNT_EN.
- When defined:
  - Adds the grant_cnt port and four CNT_W-bit counters.
  - Counter k increments on each transfer from channel k.
  - Counters saturate at 2^CNT_W-1 (no wrap).
  - Counters clear to 0 on reset.
- When undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then a=4'b0001, in_valid=4'b0001, op_ready=1 -> in_ready=4'b0001 next edge; op_data=4'b0001, op_valid=1, S1:S0=00.
- in_valid=4'b1111 held, a=1, b=2, c=4, d=8, op_ready=1 for 8 cycles -> op_data sequence 1,2,4,8,1,2,4,8; S1:S0 sequence 00,01,10,11 repeated; no idle cycle.
- Stall: op_valid=1 with op_data=4'b0101, op_ready=0 for 3 cycles, b changed to 4'b1101 -> op_data stays 4'b0101, in_ready=0, S1:S0 unchanged.
- Drain only: FULL, op_ready=1, in_valid=0 -> op_valid=0 next edge; op_data and S1:S0 held; a later op_ready pulse causes no change.
- Reset mid-stall: rst_n=0 asserted between edges while op_valid=1 -> op_valid=0 and S1:S0=00 without waiting for clk; after release, a request on c is granted with S1:S0=10.
- With GRANT_CNT_EN and CNT_W=2: six grants to channel d -> grant_cnt[7:6]=2'b11 (saturated), other counters 0; reset clears all to 0.

Source files
------------

// File: rtl/rr_mux4_sched.sv
// rr_mux4_sched: round-robin arbiter for four valid/ready channels feeding a
// one-entry output register and the registered S1:S0 select of the 4:1 mux.
// Optional feature: define GRANT_CNT_EN to add saturating per-channel grant
// counters on the grant_cnt port. The default build has no counters.

module rr_mux4_sched #(
  parameter int unsigned WIDTH = 4
`ifdef GRANT_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic             S0,
  output logic             S1,
  output logic [WIDTH-1:0] op_data,
  output logic             op_valid,
  input  logic             op_ready
`ifdef GRANT_CNT_EN
  ,
  output logic [4*CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_ok;
  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic             xfer;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      if (!win_found && in_valid[SEL_W'(ptr_q + SEL_W'(i))]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'(ptr_q + SEL_W'(i));
      end
    end
  end

  // The register can take a word when empty or when it drains this cycle;
  // held low in reset so nothing is accepted while rst_n is asserted.
  always_comb begin
    load_ok  = rst_n & ((state_q == ST_EMPTY) | (op_ready & (state_q == ST_FULL)));
    xfer     = load_ok & win_found;
    in_ready = xfer ? (4'b0001 << win_idx) : 4'b0000;
  end

  // Data steering for the winning channel.
  always_comb begin
    win_data = a;
    case (win_idx)
      2'd0:    win_data = a;
      2'd1:    win_data = b;
      2'd2:    win_data = c;
      default: win_data = d;
    endcase
  end

  // Next-state logic: load on transfer, drain to EMPTY when consumed without refill.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d = win_data;
      sel_d  = win_idx;
      ptr_d  = win_idx;
    end
    case (state_q)
      ST_EMPTY: begin
        if (xfer) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (xfer) begin
          state_d = ST_FULL;
        end else if (op_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and datapath registers; ptr resets to 3 so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign op_valid = (state_q == ST_FULL);
  assign op_data  = data_q;
  assign S1       = sel_q[1];
  assign S0       = sel_q[0];

`ifdef GRANT_CNT_EN
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating per-channel grant counters.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q[win_idx] != {CNT_W{1'b1}})) begin
      cnt_d[win_idx] = cnt_q[win_idx] + CNT_W'(1);
    end
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux4_sched.sv
// Self-checking bench for rr_mux4_sched: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.

module tb_rr_mux4_sched;

  localparam int unsigned WIDTH = 4;
`ifdef GRANT_CNT_EN
  localparam int unsigned CNT_W = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, c = '0, d = '0;
  logic [3:0]       in_valid = '0;
  logic [3:0]       in_ready;
  logic             S0, S1;
  logic [WIDTH-1:0] op_data;
  logic             op_valid;
  logic             op_ready = 1'b0;
`ifdef GRANT_CNT_EN
  logic [4*CNT_W-1:0] grant_cnt;
`endif

  rr_mux4_sched #(
    .WIDTH(WIDTH)
`ifdef GRANT_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .S0(S0),
    .S1(S1),
    .op_data(op_data),
    .op_valid(op_valid),
    .op_ready(op_ready)
`ifdef GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the output register as one optional word plus the
  // channel index of the most recent grant.
  bit         m_valid;
  logic [3:0] m_data;
  int         m_sel;
  int         m_ptr;
  int         m_cnt[4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 3;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endtask

  function automatic int m_winner(input logic [3:0] iv);
    for (int off = 1; off <= 4; off++) begin
      if (iv[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready(input logic [3:0] iv, input logic ordy);
    int w;
    w = m_winner(iv);
    if (!rst_n) return 4'b0000;
    if ((!m_valid || ordy) && w >= 0) return 4'(1 << w);
    return 4'b0000;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_op_valid"}, 32'(op_valid), 32'(m_valid));
    check_eq({tag, "_op_data"},  32'(op_data),  32'(m_data));
    check_eq({tag, "_sel"},      32'({S1, S0}), 32'(m_sel));
`ifdef GRANT_CNT_EN
    begin
      logic [4*CNT_W-1:0] exp_cnt;
      for (int k = 0; k < 4; k++) exp_cnt[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
      check_eq({tag, "_grant_cnt"}, 32'(grant_cnt), 32'(exp_cnt));
    end
`endif
  endtask

  // One clock of traffic: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input logic [3:0] iv, input logic [3:0] va, input logic [3:0] vb,
                      input logic [3:0] vc, input logic [3:0] vd, input logic ordy,
                      input string tag);
    logic [3:0] exp_r;
    logic [3:0] chan[4];
    int w;
    in_valid = iv; a = va; b = vb; c = vc; d = vd; op_ready = ordy;
    chan[0] = va; chan[1] = vb; chan[2] = vc; chan[3] = vd;
    #1;
    exp_r = m_ready(iv, ordy);
    w = m_winner(iv);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'(exp_r));
    @(posedge clk);
    #1;
    if (exp_r != 4'b0000) begin
      m_valid = 1'b1;
      m_data  = chan[w];
      m_sel   = w;
      m_ptr   = w;
`ifdef GRANT_CNT_EN
      if (m_cnt[w] < (1 << CNT_W) - 1) m_cnt[w]++;
`endif
    end else if (ordy && m_valid) begin
      m_valid = 1'b0;
    end
    check_outputs(tag);
  endtask

  // Assert reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    in_valid = 4'b1111;
    op_ready = 1'b1;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, "_async"});
    check_eq({tag, "_in_ready_rst"}, 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    check_outputs({tag, "_held"});
    #2;
    rst_n = 1'b1;
  endtask

  int exp_seq[4] = '{1, 2, 4, 8};

  initial begin
    model_reset();

    // First grant after reset goes to channel 0.
    do_reset("rst0");
    step(4'b0001, 4'b0001, 4'h0, 4'h0, 4'h0, 1'b1, "first");
    check_eq("first_data_const", 32'(op_data), 32'h1);
    check_eq("first_sel_const", 32'({S1, S0}), 32'h0);

    // Continuous all-channel requests rotate 0,1,2,3 with no bubble.
    do_reset("rst1");
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 4'd1, 4'd2, 4'd4, 4'd8, 1'b1, "rr");
      check_eq("rr_seq_data", 32'(op_data), 32'(exp_seq[i % 4]));
      check_eq("rr_seq_sel", 32'({S1, S0}), 32'(i % 4));
      check_eq("rr_seq_valid", 32'(op_valid), 32'h1);
    end

    // Stall holds the word and back-pressures new requests.
    step(4'b0001, 4'b0101, 4'h0, 4'h0, 4'h0, 1'b1, "stall_load");
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, 4'b0101, 4'b1101, 4'h0, 4'h0, 1'b0, "stall");
      check_eq("stall_data_const", 32'(op_data), 32'h5);
      check_eq("stall_in_ready_const", 32'(in_ready), 32'h0);
    end

    // Drain without refill, then op_ready while empty is ignored.
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "drain");
    check_eq("drain_valid_const", 32'(op_valid), 32'h0);
    check_eq("drain_data_const", 32'(op_data), 32'h5);
    step(4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "idle_ready");

    // Reset in the middle of a stall, then a request on c.
    step(4'b1000, 4'h0, 4'h0, 4'h0, 4'b1001, 1'b1, "pre_mid");
    step(4'b1000, 4'h0, 4'h0, 4'h0, 4'b0110, 1'b0, "mid_stall");
    #3;
    do_reset("rst_mid");
    step(4'b0100, 4'h0, 4'h0, 4'b0011, 4'h0, 1'b1, "after_rst");
    check_eq("after_rst_sel_const", 32'({S1, S0}), 32'h2);

`ifdef GRANT_CNT_EN
    // Counter saturation on channel d.
    do_reset("rst_cnt");
    for (int i = 0; i < 6; i++) step(4'b1000, 4'h0, 4'h0, 4'h0, 4'(i), 1'b1, "cnt");
    check_eq("cnt_sat_const", 32'(grant_cnt), 32'h000000C0);
    do_reset("rst_cnt_clr");
    check_eq("cnt_clr_const", 32'(grant_cnt), 32'h0);
`endif

    // Randomized traffic against the model.
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), ($urandom_range(0, 3) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
